// File: rtl/multicycle_ctrl_unit_pkg.sv
// Shared encodings for the multicycle RV32 control unit: FSM states,
// opcodes, ALU operations, datapath select codes and trap causes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RESET  = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC_R = 4'd3,
    ST_EXEC_I = 4'd4,
    ST_WB_ALU = 4'd5,
    ST_ADDR   = 4'd6,
    ST_MEM_LD = 4'd7,
    ST_WB_LD  = 4'd8,
    ST_MEM_ST = 4'd9,
    ST_BRANCH = 4'd10,
    ST_LUI    = 4'd11,
    ST_JAL    = 4'd12,
    ST_TRAP   = 4'd13
  } state_e;

  // Instruction classes the ALU decoder distinguishes.
  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_R    = 2'd1,
    CLS_I    = 2'd2,
    CLS_BR   = 2'd3
  } op_class_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_TRAP   = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_REG   = 2'd1;
  localparam logic [1:0] SRCA_OLDPC = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Instruction class used to select the ALU decoding table.
  function automatic op_class_e opcode_class(input logic [6:0] opcode);
    case (opcode)
      OPC_R:      opcode_class = CLS_R;
      OPC_I:      opcode_class = CLS_I;
      OPC_BRANCH: opcode_class = CLS_BR;
      default:    opcode_class = CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_unit_alu_decoder.sv
// Combinational ALU operation decode from instruction class and funct fields.
// Flags funct combinations the datapath cannot execute.
module alu_decoder
  import ctrl_pkg::*;
(
  input  op_class_e   op_class_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  output logic [3:0]  alu_op_o,
  output logic        illegal_o
);

  // Map class/funct3/funct7 onto an ALU operation and a legality flag.
  always_comb begin
    alu_op_o  = ALU_ADD;
    illegal_o = 1'b0;
    case (op_class_i)
      CLS_R: begin
        if (funct7_i == F7_BASE) begin
          case (funct3_i)
            3'b000:  alu_op_o = ALU_ADD;
            3'b001:  alu_op_o = ALU_SLL;
            3'b010:  alu_op_o = ALU_SLT;
            3'b100:  alu_op_o = ALU_XOR;
            3'b101:  alu_op_o = ALU_SRL;
            3'b110:  alu_op_o = ALU_OR;
            3'b111:  alu_op_o = ALU_AND;
            default: illegal_o = 1'b1;
          endcase
        end else if (funct7_i == F7_ALT) begin
          case (funct3_i)
            3'b000:  alu_op_o = ALU_SUB;
            3'b101:  alu_op_o = ALU_SRA;
            default: illegal_o = 1'b1;
          endcase
        end else begin
          illegal_o = 1'b1;
        end
      end
      CLS_I: begin
        // funct7 only distinguishes SRAI from SRLI; elsewhere it is immediate bits.
        case (funct3_i)
          3'b000:  alu_op_o = ALU_ADD;
          3'b001:  alu_op_o = ALU_SLL;
          3'b010:  alu_op_o = ALU_SLT;
          3'b100:  alu_op_o = ALU_XOR;
          3'b101:  alu_op_o = (funct7_i == F7_ALT) ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op_o = ALU_OR;
          3'b111:  alu_op_o = ALU_AND;
          default: illegal_o = 1'b1;
        endcase
      end
      CLS_BR: begin
        // Equality branches compare via SUB/zero, ordered ones via SLT.
        case (funct3_i)
          3'b000, 3'b001: alu_op_o = ALU_SUB;
          3'b100, 3'b101: alu_op_o = ALU_SLT;
          default:        illegal_o = 1'b1;
        endcase
      end
      default: begin
        alu_op_o  = ALU_ADD;
        illegal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Multicycle RV32 control FSM. Sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable and select each cycle. Memory states wait
// on mem_ready with a bounded timeout that raises a trap.
module multicycle_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 16,
  parameter int CNT_W         = 5,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_i,
  input  logic        alu_zero_i,
  input  logic        alu_lt_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic [1:0]  pc_src_o,
  output logic        ir_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        iord_o,
  output logic        reg_write_o,
  output logic [1:0]  wb_sel_o,
  output logic [1:0]  alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [2:0]  imm_sel_o,
  output logic [3:0]  alu_op_o,
  output logic        load_a_o,
  output logic        load_b_o,
  output logic        load_aluout_o,
  output logic        load_mdr_o,
  output logic        exception_o,
  output logic [1:0]  exc_cause_o,
  output logic [3:0]  state_out_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  logic       ready_s;
  logic       wait_trap_s;
  logic       taken_s;
  logic [3:0] dec_op_s;
  logic       dec_illegal_s;
  logic       unused_instr_s;

  assign opcode_s       = instr_i[6:0];
  assign funct3_s       = instr_i[14:12];
  assign funct7_s       = instr_i[31:25];
  assign unused_instr_s = ^{instr_i[24:15], instr_i[11:7]};

  // Without the handshake every memory access completes in one cycle.
  assign ready_s     = (MEM_HANDSHAKE != 0) ? mem_ready_i : 1'b1;
  // Ready in the same cycle as the limit wins, so only a missing ready traps.
  assign wait_trap_s = !ready_s && (cnt_q == TIMEOUT_CNT);

  assign state_out_o = state_q;
  assign exc_cause_o = cause_q;

  alu_decoder u_alu_decoder (
    .op_class_i (opcode_class(opcode_s)),
    .funct3_i   (funct3_s),
    .funct7_i   (funct7_s),
    .alu_op_o   (dec_op_s),
    .illegal_o  (dec_illegal_s)
  );

  // Branch condition selected by funct3 from the ALU flags.
  always_comb begin
    case (funct3_s)
      3'b000:  taken_s = alu_zero_i;
      3'b001:  taken_s = !alu_zero_i;
      3'b100:  taken_s = alu_lt_i;
      3'b101:  taken_s = !alu_lt_i;
      default: taken_s = 1'b0;
    endcase
  end

  // Next-state, wait-counter and datapath control; every output defaults to 0.
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    cause_d       = cause_q;
    pc_write_o    = 1'b0;
    pc_src_o      = PC_ALU;
    ir_write_o    = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    iord_o        = 1'b0;
    reg_write_o   = 1'b0;
    wb_sel_o      = WB_ALUOUT;
    alu_src_a_o   = SRCA_PC;
    alu_src_b_o   = SRCB_REG;
    imm_sel_o     = IMM_I;
    alu_op_o      = ALU_ADD;
    load_a_o      = 1'b0;
    load_b_o      = 1'b0;
    load_aluout_o = 1'b0;
    load_mdr_o    = 1'b0;
    exception_o   = 1'b0;
    case (state_q)
      ST_RESET: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        if (ready_s) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = ST_DECODE;
        end else if (wait_trap_s) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DECODE: begin
        load_a_o      = 1'b1;
        load_b_o      = 1'b1;
        alu_src_a_o   = SRCA_OLDPC;
        alu_src_b_o   = SRCB_IMM;
        imm_sel_o     = IMM_B;
        load_aluout_o = 1'b1;
        case (opcode_s)
          OPC_R:               state_d = ST_EXEC_R;
          OPC_I:               state_d = ST_EXEC_I;
          OPC_LOAD, OPC_STORE: state_d = ST_ADDR;
          OPC_BRANCH:          state_d = ST_BRANCH;
          OPC_LUI:             state_d = ST_LUI;
          OPC_JAL:             state_d = ST_JAL;
          default: begin
            state_d = ST_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_EXEC_R, ST_EXEC_I: begin
        alu_src_a_o   = SRCA_REG;
        alu_src_b_o   = (state_q == ST_EXEC_I) ? SRCB_IMM : SRCB_REG;
        alu_op_o      = dec_op_s;
        load_aluout_o = 1'b1;
        if (dec_illegal_s) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_WB_ALU;
        end
      end
      ST_WB_ALU: begin
        reg_write_o = 1'b1;
        wb_sel_o    = WB_ALUOUT;
        state_d     = ST_FETCH;
      end
      ST_ADDR: begin
        alu_src_a_o   = SRCA_REG;
        alu_src_b_o   = SRCB_IMM;
        load_aluout_o = 1'b1;
        if (opcode_s == OPC_STORE) begin
          imm_sel_o = IMM_S;
          state_d   = ST_MEM_ST;
        end else begin
          imm_sel_o = IMM_I;
          state_d   = ST_MEM_LD;
        end
      end
      ST_MEM_LD, ST_MEM_ST: begin
        iord_o      = 1'b1;
        mem_read_o  = (state_q == ST_MEM_LD);
        mem_write_o = (state_q == ST_MEM_ST);
        if (ready_s) begin
          load_mdr_o = (state_q == ST_MEM_LD);
          state_d    = (state_q == ST_MEM_LD) ? ST_WB_LD : ST_FETCH;
        end else if (wait_trap_s) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WB_LD: begin
        reg_write_o = 1'b1;
        wb_sel_o    = WB_MDR;
        state_d     = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a_o = SRCA_REG;
        alu_src_b_o = SRCB_REG;
        alu_op_o    = dec_op_s;
        if (dec_illegal_s) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          pc_write_o = taken_s;
          pc_src_o   = taken_s ? PC_ALUOUT : PC_ALU;
          state_d    = ST_FETCH;
        end
      end
      ST_LUI: begin
        alu_src_a_o   = SRCA_ZERO;
        alu_src_b_o   = SRCB_IMM;
        imm_sel_o     = IMM_U;
        load_aluout_o = 1'b1;
        state_d       = ST_WB_ALU;
      end
      ST_JAL: begin
        // PC already holds the return address (PC+4); the ALU forms old_pc+imm.
        reg_write_o = 1'b1;
        wb_sel_o    = WB_PC;
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_IMM;
        imm_sel_o   = IMM_J;
        pc_write_o  = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_TRAP: begin
        exception_o = 1'b1;
        pc_write_o  = 1'b1;
        pc_src_o    = PC_TRAP;
        state_d     = ST_FETCH;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // State, wait counter and sticky trap cause; rst forces the idle RESET state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Scoreboard bench: a reference model expands each instruction into per-cycle
// input plans and expected control vectors; a monitor compares every cycle.
`timescale 1ns/1ps
module tb_multicycle_ctrl_unit;
  import ctrl_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr;
  logic        alu_zero, alu_lt, mem_ready;
  logic        pc_write, ir_write, mem_read, mem_write, iord, reg_write;
  logic        load_a, load_b, load_aluout, load_mdr, exception;
  logic [1:0]  pc_src, wb_sel, alu_src_a, alu_src_b, exc_cause;
  logic [2:0]  imm_sel;
  logic [3:0]  alu_op, state_out;

  always #5 clk = ~clk;

  multicycle_ctrl_unit #(.MEM_TIMEOUT(TO), .CNT_W(5), .MEM_HANDSHAKE(1)) dut (
    .clk(clk), .rst(rst), .instr_i(instr), .alu_zero_i(alu_zero), .alu_lt_i(alu_lt),
    .mem_ready_i(mem_ready), .pc_write_o(pc_write), .pc_src_o(pc_src),
    .ir_write_o(ir_write), .mem_read_o(mem_read), .mem_write_o(mem_write),
    .iord_o(iord), .reg_write_o(reg_write), .wb_sel_o(wb_sel),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .imm_sel_o(imm_sel),
    .alu_op_o(alu_op), .load_a_o(load_a), .load_b_o(load_b),
    .load_aluout_o(load_aluout), .load_mdr_o(load_mdr), .exception_o(exception),
    .exc_cause_o(exc_cause), .state_out_o(state_out)
  );

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write, mem_read, mem_write, iord, reg_write;
    logic [1:0] wb_sel, alu_src_a, alu_src_b;
    logic [2:0] imm_sel;
    logic [3:0] alu_op;
    logic       load_a, load_b, load_aluout, load_mdr, exception;
    logic [1:0] exc_cause;
  } out_t;

  typedef struct { logic [31:0] ins; logic rdy, z, lt; } stim_t;
  typedef struct { out_t o; bit op_dc; } exp_t;

  stim_t       stim_q[$];
  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [1:0]  last_cause = 2'b00;
  logic [31:0] cur_ins = 32'h0;
  out_t        act_s;

  // Gather the DUT outputs into one comparable vector.
  always_comb begin
    act_s = '0;
    act_s.state = state_out;     act_s.pc_write = pc_write;   act_s.pc_src = pc_src;
    act_s.ir_write = ir_write;   act_s.mem_read = mem_read;   act_s.mem_write = mem_write;
    act_s.iord = iord;           act_s.reg_write = reg_write; act_s.wb_sel = wb_sel;
    act_s.alu_src_a = alu_src_a; act_s.alu_src_b = alu_src_b; act_s.imm_sel = imm_sel;
    act_s.alu_op = alu_op;       act_s.load_a = load_a;       act_s.load_b = load_b;
    act_s.load_aluout = load_aluout; act_s.load_mdr = load_mdr;
    act_s.exception = exception; act_s.exc_cause = exc_cause;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic out_t blank(input logic [3:0] s);
    out_t o = '0;
    o.state = s;
    o.exc_cause = last_cause;
    return o;
  endfunction

  task automatic push(input out_t o, input bit dc, input logic rdy, input logic z, input logic lt);
    stim_t s;
    exp_t e;
    s.ins = cur_ins; s.rdy = rdy; s.z = z; s.lt = lt;
    e.o = o; e.op_dc = dc;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // d = cycle in which ready arrives; d > TO means it never does.
  task automatic wait_phase(input out_t base, input out_t done, input int d, output bit to);
    to = 1'b0;
    for (int k = 0; k <= TO; k++) begin
      if (k == d) begin
        push(done, 1'b0, 1'b1, rb(), rb());
        return;
      end
      push(base, 1'b0, 1'b0, rb(), rb());
      if (k == TO) begin
        to = 1'b1;
        return;
      end
    end
  endtask

  task automatic trap(input logic [1:0] c);
    out_t b;
    last_cause = c;
    b = blank(ST_TRAP);
    b.exception = 1'b1; b.pc_write = 1'b1; b.pc_src = 2'd2;
    push(b, 1'b0, rb(), rb(), rb());
  endtask

  task automatic wb_alu();
    out_t b = blank(ST_WB_ALU);
    b.reg_write = 1'b1;
    push(b, 1'b0, rb(), rb(), rb());
  endtask

  // ALU operation an R/I instruction asks for, and whether it exists.
  task automatic ref_alu(input bit is_r, input logic [2:0] f3, input logic [6:0] f7,
                         output logic [3:0] op, output bit ok);
    logic [3:0] base_tbl [8];
    base_tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_ADD, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    op = base_tbl[f3];
    ok = (f3 != 3'd3);
    if (is_r) begin
      if (f7 == 7'h20) begin
        ok = (f3 == 3'd0) || (f3 == 3'd5);
        op = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
      end else if (f7 != 7'h00) begin
        ok = 1'b0;
      end
    end else if (f3 == 3'd5 && f7 == 7'h20) begin
      op = ALU_SRA;
    end
  endtask

  // Expand one instruction into its cycle-by-cycle plan and expectations.
  task automatic gen(input logic [31:0] ins, input int fd, input int md, input logic bz, input logic blt);
    out_t b, r;
    bit to, ok, legal, taken;
    logic [3:0] op;
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    cur_ins = ins;
    b = blank(ST_FETCH); b.mem_read = 1'b1; b.alu_src_b = 2'd1; b.alu_op = ALU_ADD;
    r = b; r.ir_write = 1'b1; r.pc_write = 1'b1; r.pc_src = 2'd0;
    wait_phase(b, r, fd, to);
    if (to) begin trap(2'b10); return; end
    b = blank(ST_DECODE);
    b.load_a = 1'b1; b.load_b = 1'b1; b.alu_src_a = 2'd2; b.alu_src_b = 2'd2;
    b.imm_sel = 3'd2; b.alu_op = ALU_ADD; b.load_aluout = 1'b1;
    push(b, 1'b0, rb(), rb(), rb());
    case (opc)
      7'b0110011, 7'b0010011: begin
        ref_alu(opc == 7'b0110011, f3, f7, op, ok);
        b = blank((opc == 7'b0110011) ? ST_EXEC_R : ST_EXEC_I);
        b.alu_src_a = 2'd1; b.load_aluout = 1'b1; b.alu_op = op;
        b.alu_src_b = (opc == 7'b0110011) ? 2'd0 : 2'd2;
        push(b, !ok, rb(), rb(), rb());
        if (!ok) trap(2'b01);
        else wb_alu();
      end
      7'b0000011, 7'b0100011: begin
        b = blank(ST_ADDR);
        b.alu_src_a = 2'd1; b.alu_src_b = 2'd2; b.alu_op = ALU_ADD; b.load_aluout = 1'b1;
        b.imm_sel = (opc == 7'b0100011) ? 3'd1 : 3'd0;
        push(b, 1'b0, rb(), rb(), rb());
        if (opc == 7'b0000011) begin
          b = blank(ST_MEM_LD); b.mem_read = 1'b1; b.iord = 1'b1;
          r = b; r.load_mdr = 1'b1;
        end else begin
          b = blank(ST_MEM_ST); b.mem_write = 1'b1; b.iord = 1'b1;
          r = b;
        end
        wait_phase(b, r, md, to);
        if (to) trap(2'b10);
        else if (opc == 7'b0000011) begin
          b = blank(ST_WB_LD); b.reg_write = 1'b1; b.wb_sel = 2'd1;
          push(b, 1'b0, rb(), rb(), rb());
        end
      end
      7'b1100011: begin
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd5);
        taken = (f3 == 3'd0) ? bz : (f3 == 3'd1) ? !bz : (f3 == 3'd4) ? blt : !blt;
        b = blank(ST_BRANCH);
        b.alu_src_a = 2'd1; b.alu_src_b = 2'd0;
        b.alu_op = (f3 >= 3'd4) ? ALU_SLT : ALU_SUB;
        if (legal && taken) begin b.pc_write = 1'b1; b.pc_src = 2'd1; end
        push(b, !legal, rb(), bz, blt);
        if (!legal) trap(2'b01);
      end
      7'b0110111: begin
        b = blank(ST_LUI);
        b.alu_src_a = 2'd3; b.alu_src_b = 2'd2; b.imm_sel = 3'd3; b.load_aluout = 1'b1;
        push(b, 1'b0, rb(), rb(), rb());
        wb_alu();
      end
      7'b1101111: begin
        b = blank(ST_JAL);
        b.reg_write = 1'b1; b.wb_sel = 2'd2; b.alu_src_a = 2'd2; b.alu_src_b = 2'd2;
        b.imm_sel = 3'd4; b.pc_write = 1'b1; b.pc_src = 2'd0;
        push(b, 1'b0, rb(), rb(), rb());
      end
      default: trap(2'b01);
    endcase
  endtask

  function automatic int rnd_delay();
    int p = $urandom_range(0, 99);
    if (p < 65) return 0;
    if (p < 88) return $urandom_range(1, 3);
    if (p < 94) return TO;
    return TO + 1;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w = $urandom;
    logic [6:0] opcs [8];
    logic [6:0] f7s [4];
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
             7'b1100011, 7'b0110111, 7'b1101111, 7'b0000000};
    f7s  = '{7'h00, 7'h20, 7'h00, 7'h01};
    w[6:0] = opcs[$urandom_range(0, 7)];
    if (w[6:0] == 7'b0000000) w[6:0] = 7'($urandom) | 7'b0001000;
    if (w[6:0] == 7'b0110011 || w[6:0] == 7'b0010011) w[31:25] = f7s[$urandom_range(0, 3)];
    return w;
  endfunction

  // Monitor: pop the next expected vector and compare it each cycle.
  always @(negedge clk) begin
    exp_t e;
    out_t a;
    if (mon_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_s;
      if (e.op_dc) begin a.alu_op = 4'd0; e.o.alu_op = 4'd0; end
      chk($sformatf("cycle%0d_state%0d", cyc, e.o.state), a, e.o);
      cyc++;
    end
  end

  task automatic drive(input stim_t s);
    instr = s.ins; mem_ready = s.rdy; alu_zero = s.z; alu_lt = s.lt;
  endtask

  initial begin
    bit found;
    instr = 32'h0; alu_zero = 1'b0; alu_lt = 1'b0; mem_ready = 1'b0;
    push(blank(ST_RESET), 1'b0, 1'b1, 1'b0, 1'b0);
    gen(32'h002081B3, 0, 0, 1'b0, 1'b0);        // ADD
    gen(32'h402081B3, 1, 0, 1'b0, 1'b0);        // SUB
    gen(32'h0000A283, 0, 3, 1'b0, 1'b0);        // LW, 3 wait cycles
    gen(32'h0050A023, 0, TO + 1, 1'b0, 1'b0);   // SW, timeout
    gen(32'h00209463, 0, 0, 1'b0, 1'b0);        // BNE taken
    gen(32'h00209463, 0, 0, 1'b1, 1'b0);        // BNE not taken
    gen(32'h0020C463, 0, 0, 1'b0, 1'b1);        // BLT taken
    gen(32'h0020C463, 0, 0, 1'b0, 1'b0);        // BLT not taken
    gen(32'h0020D463, 0, 0, 1'b0, 1'b0);        // BGE taken
    gen(32'h0020D463, 0, 0, 1'b0, 1'b1);        // BGE not taken
    gen(32'h00000000, 0, 0, 1'b0, 1'b0);        // illegal opcode
    gen(32'h123452B7, 0, 0, 1'b0, 1'b0);        // LUI
    gen(32'h008000EF, 0, 0, 1'b0, 1'b0);        // JAL
    gen(32'h002081B3, TO, 0, 1'b0, 1'b0);       // ready on the limit cycle
    gen(32'h002081B3, TO + 1, 0, 1'b0, 1'b0);   // fetch timeout
    gen(32'h0000A283, 0, TO, 1'b0, 1'b0);       // LW ready on the limit cycle
    for (int i = 0; i < 150; i++) gen(rnd_instr(), rnd_delay(), rnd_delay(), rb(), rb());

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    drive(stim_q.pop_front());
    while (stim_q.size() > 0) begin
      @(posedge clk);
      #1;
      drive(stim_q.pop_front());
    end
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a store that is still waiting for memory.
    @(posedge clk);
    #1;
    instr = 32'h0050A023; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("mem_st_state", 32'(state_out), 32'(ST_MEM_ST));
    chk("mem_st_write", 32'(mem_write), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", act_s, 32'h0);
    mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("reset_hold_quiet", {28'h0, state_out | {1'b0, pc_write, reg_write, mem_write}}, 32'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 2 && !found; k++) begin
      @(posedge clk);
      #1;
      if (state_out == ST_FETCH) found = 1'b1;
    end
    chk("fetch_after_reset", 32'(found), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
